// File: rtl/spi_reg_write_arbiter.sv
// PWM/output-enable config register bank with a single write port
// shared between NUM_REQ requesters by round-robin arbitration.
module spi_reg_write_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_ADDR = 4,
  parameter int GW       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [15:0]               en_reg_out,
  output logic [15:0]               en_reg_pwm,
  output logic [7:0]                pwm_duty_cycle,
  output logic                      wr_done,
  output logic [GW-1:0]             wr_grant,
  output logic                      wr_err
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state;
  logic [GW-1:0]       last_grant;
  logic [GW-1:0]       hold_idx;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_data;

  logic                found;
  logic [GW-1:0]       pick;
  logic [GW-1:0]       cand;
  int                  idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Search starts just after the last winner so nobody is starved.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant) + k) % NUM_REQ;
      cand = GW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel_addr = req_addr[int'(pick)*ADDR_W +: ADDR_W];
  assign sel_data = req_data[int'(pick)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= GW'(NUM_REQ-1);
      hold_idx       <= '0;
      hold_addr      <= '0;
      hold_data      <= '0;
      req_ready      <= '0;
      wr_done        <= 1'b0;
      wr_grant       <= '0;
      wr_err         <= 1'b0;
      en_reg_out     <= '0;
      en_reg_pwm     <= '0;
      pwm_duty_cycle <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= '0;
          wr_done   <= 1'b0;
          wr_grant  <= '0;
          wr_err    <= 1'b0;
          if (found) begin
            hold_idx  <= pick;
            hold_addr <= sel_addr;
            hold_data <= sel_data;
            req_ready <= NUM_REQ'(1) << pick;
            wr_done   <= 1'b1;
            wr_grant  <= pick;
            wr_err    <= sel_addr > ADDR_W'(MAX_ADDR);
            state     <= WRITE;
          end
        end
        WRITE: begin
          req_ready  <= '0;
          wr_done    <= 1'b0;
          wr_grant   <= '0;
          wr_err     <= 1'b0;
          last_grant <= hold_idx;
          state      <= IDLE;
          // wr_err still holds this transfer's out-of-range flag
          if (!wr_err) begin
            case (hold_addr)
              ADDR_W'(0): en_reg_out[7:0]  <= hold_data[7:0];
              ADDR_W'(1): en_reg_out[15:8] <= hold_data[7:0];
              ADDR_W'(2): en_reg_pwm[7:0]  <= hold_data[7:0];
              ADDR_W'(3): en_reg_pwm[15:8] <= hold_data[7:0];
              ADDR_W'(4): pwm_duty_cycle   <= hold_data[7:0];
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
